// File: rtl/i2c_reg_ctrl.sv
// I2C register-file controller: pointer/write/read protocol on top of a byte-level
// I2C slave engine, plus an internal write port that loses to I2C on collisions.
module i2c_reg_ctrl #(
   parameter int unsigned NUM_REGS   = 8,
   parameter logic [7:0]  RD_OOR_VAL = 8'h00
) (
   input  logic                    i_sys_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_rw,
   input  logic                    i_stop,
   input  logic                    i_rx_valid,
   input  logic [7:0]              i_rx_data,
   input  logic                    i_rd_req,
   output logic [7:0]              o_tx_data,
   output logic                    o_tx_valid,
   input  logic                    i_int_we,
   input  logic [7:0]              i_int_addr,
   input  logic [7:0]              i_int_wdata,
   output logic                    o_int_drop,
   output logic [8*NUM_REGS-1:0]   o_regs,
   output logic [7:0]              o_pointer,
   output logic                    o_err
);

   localparam int unsigned DW       = 8;
   localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PTR  = 2'd1,
      ST_WR   = 2'd2,
      ST_RD   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  ptr_q, ptr_d;
   logic [DW-1:0]  regs_q [NUM_REGS];
   logic [DW-1:0]  regs_d [NUM_REGS];
   logic [DW-1:0]  tx_data_q, tx_data_d;
   logic           tx_valid_q, tx_valid_d;
   logic           int_drop_q, int_drop_d;
   logic           err_q, err_d;

   logic           ptr_load_c;
   logic           i2c_wr_c;
   logic           rd_c;
   logic           ptr_in_range_c;
   logic           int_in_range_c;
   logic           i2c_wr_ok_c;
   logic           int_hit_c;
   logic           int_wr_ok_c;
   logic [DW-1:0]  ptr_inc_c;
   logic [DW-1:0]  rd_sel_c;

   // State register
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: START always wins over STOP
   always_comb begin
      state_d = state_q;
      if (i_start) begin
         state_d = i_rw ? ST_RD : ST_PTR;
      end else if (i_stop) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_PTR && i_rx_valid) begin
         state_d = ST_WR;
      end
   end

   // Per-state transfer actions; bus events in the same cycle take precedence
   always_comb begin
      ptr_load_c = 1'b0;
      i2c_wr_c   = 1'b0;
      rd_c       = 1'b0;
      if (!i_start && !i_stop) begin
         case (state_q)
            ST_PTR:  ptr_load_c = i_rx_valid;
            ST_WR:   i2c_wr_c   = i_rx_valid;
            ST_RD:   rd_c       = i_rd_req;
            default: ;
         endcase
      end
   end

   assign ptr_in_range_c = (ptr_q <= LAST_IDX);
   assign int_in_range_c = (i_int_addr <= LAST_IDX);
   assign i2c_wr_ok_c    = i2c_wr_c && ptr_in_range_c;
   assign int_hit_c      = i_int_we && int_in_range_c;
   assign int_wr_ok_c    = int_hit_c && !(i2c_wr_ok_c && (i_int_addr == ptr_q));
   // In-range pointers wrap at the register count, out-of-range ones modulo 256
   assign ptr_inc_c      = (ptr_q == LAST_IDX) ? 8'h00 : ptr_q + 8'h01;

   always_comb begin
      rd_sel_c = 8'h00;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (ptr_q == 8'(i)) rd_sel_c = regs_q[i];
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         regs_d[i] = regs_q[i];
         if (i2c_wr_ok_c && ptr_q == 8'(i)) begin
            regs_d[i] = i_rx_data;
         end else if (int_wr_ok_c && i_int_addr == 8'(i)) begin
            regs_d[i] = i_int_wdata;
         end
      end
   end

   always_comb begin
      ptr_d      = ptr_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
      int_drop_d = int_hit_c && i2c_wr_ok_c && (i_int_addr == ptr_q);
      err_d      = (i2c_wr_c || rd_c) && !ptr_in_range_c;
      if (ptr_load_c) begin
         ptr_d = i_rx_data;
      end else if (i2c_wr_c || rd_c) begin
         ptr_d = ptr_inc_c;
      end
      if (rd_c) begin
         tx_valid_d = 1'b1;
         // Forward an internal write landing on the same edge as the request
         if (!ptr_in_range_c) begin
            tx_data_d = RD_OOR_VAL;
         end else if (int_wr_ok_c && i_int_addr == ptr_q) begin
            tx_data_d = i_int_wdata;
         end else begin
            tx_data_d = rd_sel_c;
         end
      end
   end

   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         int_drop_q <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         int_drop_q <= int_drop_d;
         err_q      <= err_d;
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         o_regs[8*i +: 8] = regs_q[i];
      end
   end

   assign o_tx_data  = tx_data_q;
   assign o_tx_valid = tx_valid_q;
   assign o_int_drop = int_drop_q;
   assign o_err      = err_q;
   assign o_pointer  = ptr_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed self-checking bench for i2c_reg_ctrl (NUM_REGS = 8).
module tb_i2c_reg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, rw, stop, rx_valid, rd_req, int_we;
   logic [7:0]  rx_data, int_addr, int_wdata;
   logic [7:0]  tx_data, pointer;
   logic        tx_valid, int_drop, err;
   logic [63:0] regs;

   logic [7:0]  m [8];
   int          checks = 0;
   int          errors = 0;

   i2c_reg_ctrl #(.NUM_REGS(8), .RD_OOR_VAL(8'h00)) dut (
      .i_sys_clk  (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_rw       (rw),
      .i_stop     (stop),
      .i_rx_valid (rx_valid),
      .i_rx_data  (rx_data),
      .i_rd_req   (rd_req),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .i_int_we   (int_we),
      .i_int_addr (int_addr),
      .i_int_wdata(int_wdata),
      .o_int_drop (int_drop),
      .o_regs     (regs),
      .o_pointer  (pointer),
      .o_err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   function automatic logic [63:0] packm();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = m[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clr();
      start = 0; rw = 0; stop = 0; rx_valid = 0; rd_req = 0; int_we = 0;
   endtask

   task automatic do_start(input logic dir);
      start = 1; rw = dir; step(); clr();
   endtask

   task automatic do_stop();
      stop = 1; step(); clr();
   endtask

   task automatic do_rx(input logic [7:0] d);
      rx_valid = 1; rx_data = d; step(); clr();
   endtask

   task automatic do_int(input logic [7:0] a, input logic [7:0] d);
      int_we = 1; int_addr = a; int_wdata = d; step(); clr();
   endtask

   // One read request: response must appear exactly one cycle later, then drop
   task automatic do_rd(input string tag, input logic [7:0] exp);
      rd_req = 1; step(); clr();
      chk({tag, "_valid"}, 64'(tx_valid), 64'd1);
      chk({tag, "_data"}, 64'(tx_data), 64'(exp));
      step();
      chk({tag, "_valid_drop"}, 64'(tx_valid), 64'd0);
   endtask

   initial begin
      clr();
      rx_data = 0; int_addr = 0; int_wdata = 0;
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
      rst = 1;
      step(); step();
      chk("rst_ptr", 64'(pointer), 64'h0);
      chk("rst_regs", regs, 64'h0);
      chk("rst_txv", 64'(tx_valid), 64'h0);
      chk("rst_txd", 64'(tx_data), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_drop", 64'(int_drop), 64'h0);
      rst = 0;
      step();

      // Burst write
      do_start(1'b0);
      do_rx(8'h02); do_rx(8'hAA); do_rx(8'hBB);
      do_stop();
      m[2] = 8'hAA; m[3] = 8'hBB;
      chk("burst_regs", regs, 64'h00000000_BBAA0000);
      chk("burst_ptr", 64'(pointer), 64'h04);
      chk("burst_err", 64'(err), 64'h0);
      do_rx(8'h77);
      chk("idle_rx_regs", regs, packm());
      chk("idle_rx_ptr", 64'(pointer), 64'h04);

      // Preload via internal port
      do_int(8'h06, 8'h66); do_int(8'h07, 8'h77); do_int(8'h00, 8'h10);
      m[6] = 8'h66; m[7] = 8'h77; m[0] = 8'h10;
      chk("int_regs", regs, 64'h7766_0000_BBAA_0010);
      chk("int_drop_none", 64'(int_drop), 64'h0);

      // Combined write-pointer then read, wrapping at 8
      do_start(1'b0);
      do_rx(8'h06);
      do_start(1'b1);
      do_rd("rd6", 8'h66);
      do_rd("rd7", 8'h77);
      do_rd("rd0", 8'h10);
      chk("rd_wrap_ptr", 64'(pointer), 64'h01);
      chk("rd_no_change", regs, packm());

      // Internal write on the request edge is visible in the response
      rd_req = 1; int_we = 1; int_addr = 8'h01; int_wdata = 8'h5A;
      step(); clr();
      m[1] = 8'h5A;
      chk("fwd_valid", 64'(tx_valid), 64'd1);
      chk("fwd_data", 64'(tx_data), 64'h5A);
      chk("fwd_ptr", 64'(pointer), 64'h02);
      do_stop();

      // Out-of-range pointer write and read
      do_start(1'b0);
      do_rx(8'h0A);
      chk("oor_load_err", 64'(err), 64'h0);
      do_rx(8'h55);
      chk("oor_wr_err", 64'(err), 64'h1);
      step();
      chk("oor_wr_err_drop", 64'(err), 64'h0);
      chk("oor_wr_ptr", 64'(pointer), 64'h0B);
      chk("oor_wr_regs", regs, packm());
      do_start(1'b1);
      rd_req = 1; step(); clr();
      chk("oor_rd_valid", 64'(tx_valid), 64'h1);
      chk("oor_rd_data", 64'(tx_data), 64'h00);
      chk("oor_rd_err", 64'(err), 64'h1);
      chk("oor_rd_ptr", 64'(pointer), 64'h0C);
      do_stop();
      rd_req = 1; step(); clr();
      chk("idle_rd_valid", 64'(tx_valid), 64'h0);
      chk("idle_rd_ptr", 64'(pointer), 64'h0C);

      // Collision on reg5, then concurrent writes to distinct registers
      do_start(1'b0);
      do_rx(8'h05);
      rx_valid = 1; rx_data = 8'h11; int_we = 1; int_addr = 8'h05; int_wdata = 8'h22;
      step(); clr();
      m[5] = 8'h11;
      chk("coll_drop", 64'(int_drop), 64'h1);
      chk("coll_regs", regs, packm());
      step();
      chk("coll_drop_once", 64'(int_drop), 64'h0);
      rx_valid = 1; rx_data = 8'h33; int_we = 1; int_addr = 8'h04; int_wdata = 8'h22;
      step(); clr();
      m[6] = 8'h33; m[4] = 8'h22;
      chk("both_regs", regs, packm());
      chk("both_drop", 64'(int_drop), 64'h0);
      do_int(8'h09, 8'hEE);
      chk("int_oor_regs", regs, packm());
      chk("int_oor_drop", 64'(int_drop), 64'h0);
      do_stop();

      // START and STOP together land in PTR; reset mid-write aborts
      start = 1; stop = 1; rw = 0; step(); clr();
      do_rx(8'h03);
      chk("ss_ptr", 64'(pointer), 64'h03);
      chk("ss_regs", regs, packm());
      rst = 1; step();
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
      chk("mid_rst_regs", regs, 64'h0);
      chk("mid_rst_ptr", 64'(pointer), 64'h0);
      rst = 0; step();
      do_rx(8'h99);
      chk("post_rst_rx_regs", regs, packm());
      chk("post_rst_rx_ptr", 64'(pointer), 64'h0);
      rd_req = 1; step(); clr();
      chk("post_rst_rd", 64'(tx_valid), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
